// File: rtl/fibonacci_engine.sv
// Iterative Fibonacci / Lucas term generator with a result hold/handshake stage.
// Optional macro FIB_SATURATE_EN: overflowing sums clamp to all ones instead of wrapping.
module fibonacci_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [IDX_W-1:0]  n_i,
  input  logic              abort_i,
  input  logic              result_ready_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic              overflow_o,
  output logic              done_tick_o
);

  localparam int unsigned SUM_W = DATA_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_OP   = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [DATA_W-1:0]  r_t0;
  logic [DATA_W-1:0]  r_t1;
  logic [IDX_W-1:0]   r_n;
  logic               r_ovf;
  logic [DATA_W-1:0]  w_t0_nxt;
  logic [DATA_W-1:0]  w_t1_nxt;
  logic [IDX_W-1:0]   w_n_nxt;
  logic               w_ovf_nxt;
  logic [SUM_W-1:0]   w_sum;
  logic               w_start_ok;

  assign w_start_ok = start_i && !abort_i;
  assign w_sum      = SUM_W'(r_t0) + SUM_W'(r_t1);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort always wins and illegal encodings recover to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_OP;
      end
      S_OP: begin
        if (abort_i)                     w_state_nxt = S_IDLE;
        else if (r_n <= IDX_W'(1))       w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (abort_i || result_ready_i)   w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; done_tick is the only output that follows an input (the accept)
  always_comb begin
    ready_o     = (r_state == S_IDLE);
    busy_o      = (r_state == S_OP);
    valid_o     = (r_state == S_HOLD);
    done_tick_o = (r_state == S_HOLD) && result_ready_i && !abort_i;
    result_o    = r_t1;
    overflow_o  = r_ovf;
  end

  // Datapath next values: t1 always carries the most recent term
  always_comb begin
    w_t0_nxt  = r_t0;
    w_t1_nxt  = r_t1;
    w_n_nxt   = r_n;
    w_ovf_nxt = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_t0_nxt  = mode_i ? DATA_W'(2) : '0;
          w_t1_nxt  = DATA_W'(1);
          w_n_nxt   = n_i;
          w_ovf_nxt = 1'b0;
        end
      end
      S_OP: begin
        if (!abort_i) begin
          if (r_n == '0) begin
            w_t1_nxt = r_t0;
          end else if (r_n > IDX_W'(1)) begin
            w_t0_nxt = r_t1;
            w_n_nxt  = r_n - IDX_W'(1);
`ifdef FIB_SATURATE_EN
            w_t1_nxt = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
`else
            w_t1_nxt = w_sum[DATA_W-1:0];
`endif
            if (w_sum[DATA_W]) w_ovf_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_t0  <= '0;
      r_t1  <= '0;
      r_n   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_t0  <= w_t0_nxt;
      r_t1  <= w_t1_nxt;
      r_n   <= w_n_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

endmodule

// File: doc/fibonacci_engine.md
FIBONACCI_ENGINE -- requirements
Module: fibonacci_engine

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the result width in bits (>=8).
REQ-002 Parameter IDX_W, default 6, SHALL set the index width in bits (>=2).
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_ni  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start_i  input  1  SHALL request a computation; it is sampled only in IDLE.
REQ-006 mode_i  input  1  SHALL select the sequence: 0 = Fibonacci (seeds 0, 1), 1 = Lucas (seeds 2, 1); it is sampled with start_i.
REQ-007 n_i  input  IDX_W  SHALL carry the index of the requested term; it is sampled with start_i.
REQ-008 abort_i  input  1  SHALL cancel any computation or held result.
REQ-009 result_ready_i  input  1  SHALL be the downstream accept for the result.
REQ-010 ready_o  output  1  SHALL be high exactly in IDLE.
REQ-011 busy_o  output  1  SHALL be high exactly in OP.
REQ-012 valid_o  output  1  SHALL be high exactly in HOLD.
REQ-013 result_o  output  DATA_W  SHALL carry the computed term; it is meaningful only while valid_o is high.
REQ-014 overflow_o  output  1  SHALL be a sticky flag indicating that the current result exceeded 2^DATA_W-1.
REQ-015 done_tick_o  output  1  SHALL pulse for one cycle when valid_o and result_ready_i are both high.

Function
REQ-016 The FSM SHALL have three states, IDLE, OP and HOLD; any illegal encoding SHALL go to IDLE.
REQ-017 In IDLE with start_i=1 and abort_i=0, the block SHALL load t0 (0 for Fibonacci, 2 for Lucas), t1=1, n=n_i, clear overflow, and go to OP.
REQ-018 In OP with n=0, the block SHALL set t1=t0 and go to HOLD.
REQ-019 In OP with n=1, the block SHALL go to HOLD with t1 unchanged.
REQ-020 In OP with n>1, the block SHALL set t1=t0+t1 (computed at DATA_W+1 bits), t0=t1_old and n=n-1.
REQ-021 A carry out of the DATA_W-bit sum SHALL set overflow_o, which SHALL remain set until the next accepted start.
REQ-022 Latency SHALL be max(n_i,1) cycles from the start-sampling edge to the edge at which valid_o rises.
REQ-023 In HOLD, result_o and overflow_o SHALL be held stable until accept; with result_ready_i=1 the block SHALL go to IDLE on that edge.
REQ-024 start_i SHALL be ignored in OP and in HOLD, with no queuing.
REQ-025 abort_i=1 in OP or HOLD SHALL force IDLE on the next edge with no done_tick_o; in IDLE, abort_i SHALL take priority over start_i.
REQ-026 result_o SHALL be driven from the t1 register; no output SHALL depend combinationally on start_i, n_i or mode_i.

Reset
REQ-027 On rst_ni=0, the block SHALL immediately enter IDLE with t0, t1, n and the overflow flag at 0.
REQ-028 During and after reset: ready_o=1, busy_o=0, valid_o=0, done_tick_o=0, result_o=0, overflow_o=0.
REQ-029 Reset asserted mid-OP or mid-HOLD SHALL discard the computation; no done_tick_o SHALL follow reset release.

Configuration
REQ-030 With macro FIB_SATURATE_EN defined, an overflowing addition SHALL load t1 with all ones and later sums SHALL saturate at all ones; overflow_o behaviour is unchanged.
REQ-031 Without FIB_SATURATE_EN, sums SHALL wrap modulo 2^DATA_W.

Verification (DATA_W=32, IDX_W=6)
REQ-032 Fibonacci, n_i=30, result_ready_i=1 -> valid_o 30 cycles after start, result_o=832040, overflow_o=0, one done_tick_o.
REQ-033 Lucas n_i=0, 1 and 5 -> result_o=2, 1 and 11 respectively, each with 1-cycle latency for n_i=0 and n_i=1.
REQ-034 Fibonacci n_i=48: without the macro -> result_o=512559680 and overflow_o=1; with FIB_SATURATE_EN -> result_o=0xFFFFFFFF and overflow_o=1; n_i=47 -> 2971215073 with overflow_o=0.
REQ-035 Backpressure: result_ready_i held low 5 cycles in HOLD while start_i pulses -> valid_o and result_o stable, start ignored, done_tick_o only on the accept cycle.
REQ-036 abort_i pulsed at cycle 3 of an n_i=20 run -> IDLE next cycle, no valid_o and no done_tick_o; the next start runs normally.
REQ-037 rst_ni low mid-OP -> outputs immediately at reset values; after release, ready_o=1 and the next start computes correctly.
